operand_entry: RTL and testbench

OPERAND_ENTRY -- requirements
Module: operand_entry

---
 rtl/operand_entry.sv | 191 +++++++++++++++++++
 tb/tb_operand_entry.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/operand_entry.sv
// operand_entry: debounced hex keypad front end that builds two operands.
//
// A raw keypad press level is synchronized, debounced for DEBOUNCE_CYCLES
// stable cycles, executed once, then must be released (debounced low) before
// another key is accepted. Each accepted key edits the operand chosen by SW.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   key_valid  - raw asynchronous press level (may bounce)
//   key_code   - 0-15 hex digit, 16 backspace, 17 clear target,
//                18 clear both, 19-31 illegal
//   SW         - target select (0 = operandA, 1 = operandB), read only on execute
//   operandA/B - entered operands, zero-extended to 32 bits
//   cntA/cntB  - digits currently held in each operand
//   key_ack    - one-cycle pulse per accepted key
//   err        - one-cycle pulse, coincident with key_ack, on a rejected key
module operand_entry #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MAX_DIGITS      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    input  logic        SW,
    output logic [31:0] operandA,
    output logic [31:0] operandB,
    output logic [3:0]  cntA,
    output logic [3:0]  cntB,
    output logic        key_ack,
    output logic        err
);

    localparam int W  = 4 * MAX_DIGITS;
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]    MAXC = 4'(MAX_DIGITS);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] EXECUTE  = 2'd2;
    localparam logic [1:0] RELEASE  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] dcnt;
    logic          sync1, sync2;
    logic [4:0]    code_q;

    logic [W-1:0]  op_a, op_b;
    logic [W-1:0]  nxt_a, nxt_b;
    logic [3:0]    nxt_ca, nxt_cb;
    logic [W-1:0]  tgt_op, new_op;
    logic [3:0]    tgt_cnt, new_cnt;
    logic          reject;

    // Two-flop synchronizer for the asynchronous press level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= key_valid;
            sync2 <= sync1;
        end
    end

    // Press / release debounce FSM. The same counter serves both the press
    // debounce and the release debounce.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            dcnt   <= '0;
            code_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sync2) begin
                        state <= DEBOUNCE;
                        dcnt  <= '0;
                    end
                end
                DEBOUNCE: begin
                    if (!sync2) begin
                        state <= IDLE;
                    end else if (dcnt == LAST) begin
                        state  <= EXECUTE;
                        code_q <= key_code;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                EXECUTE: begin
                    state <= RELEASE;
                    dcnt  <= '0;
                end
                RELEASE: begin
                    if (sync2) begin
                        dcnt <= '0;
                    end else if (dcnt == LAST) begin
                        state <= IDLE;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Next operand values for the key latched in code_q; only committed in
    // EXECUTE, which is also the only place SW matters.
    always_comb begin
        nxt_a   = op_a;
        nxt_b   = op_b;
        nxt_ca  = cntA;
        nxt_cb  = cntB;
        reject  = 1'b0;
        tgt_op  = SW ? op_b : op_a;
        tgt_cnt = SW ? cntB : cntA;
        new_op  = tgt_op;
        new_cnt = tgt_cnt;

        if (code_q < 5'd16) begin
            if (tgt_cnt == 4'd0 && code_q[3:0] == 4'd0) begin
                // leading zero: accepted but changes nothing
            end else if (tgt_cnt < MAXC) begin
                new_op  = (tgt_op << 4) | W'(code_q[3:0]);
                new_cnt = tgt_cnt + 4'd1;
            end else begin
                reject = 1'b1;
            end
        end else if (code_q == 5'd16) begin
            if (tgt_cnt != 4'd0) begin
                new_op  = tgt_op >> 4;
                new_cnt = tgt_cnt - 4'd1;
            end
        end else if (code_q == 5'd17 || code_q == 5'd18) begin
            new_op  = '0;
            new_cnt = '0;
        end else begin
            reject = 1'b1;
        end

        if (SW) begin
            nxt_b  = new_op;
            nxt_cb = new_cnt;
        end else begin
            nxt_a  = new_op;
            nxt_ca = new_cnt;
        end

        if (code_q == 5'd18) begin
            nxt_a  = '0;
            nxt_b  = '0;
            nxt_ca = '0;
            nxt_cb = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a    <= '0;
            op_b    <= '0;
            cntA    <= '0;
            cntB    <= '0;
            key_ack <= 1'b0;
            err     <= 1'b0;
        end else begin
            key_ack <= 1'b0;
            err     <= 1'b0;
            if (state == EXECUTE) begin
                key_ack <= 1'b1;
                err     <= reject;
                op_a    <= nxt_a;
                op_b    <= nxt_b;
                cntA    <= nxt_ca;
                cntB    <= nxt_cb;
            end
        end
    end

    // Zero-extend the operand registers; bits above 4*MAX_DIGITS stay 0.
    always_comb begin
        operandA        = '0;
        operandB        = '0;
        operandA[W-1:0] = op_a;
        operandB[W-1:0] = op_b;
    end

endmodule

// File: tb/tb_operand_entry.sv
// Directed table-driven bench for operand_entry with DEBOUNCE_CYCLES = 4 and
// MAX_DIGITS = 4. Each table row is one press; operand state carries over
// from row to row. SW is held at the opposite value except around the
// execute edge, so every row also shows SW is only sampled there.
module tb_operand_entry;

    localparam int DC = 4;
    localparam int MD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [4:0]  key_code = '0;
    logic        SW = 1'b0;
    logic [31:0] operandA, operandB;
    logic [3:0]  cntA, cntB;
    logic        key_ack, err;

    operand_entry #(.DEBOUNCE_CYCLES(DC), .MAX_DIGITS(MD)) dut (
        .clk      (clk),
        .rst      (rst),
        .key_valid(key_valid),
        .key_code (key_code),
        .SW       (SW),
        .operandA (operandA),
        .operandB (operandB),
        .cntA     (cntA),
        .cntB     (cntB),
        .key_ack  (key_ack),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [4:0]  code;
        logic        sw;
        int          hold;
        int          acks;
        logic        err;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ca;
        logic [3:0]  cb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [4:0] code, input logic sw, input int hold,
                                input int acks, input logic e, input logic [31:0] a,
                                input logic [31:0] b, input logic [3:0] ca, input logic [3:0] cb);
        vec_t v;
        v.code = code; v.sw = sw; v.hold = hold; v.acks = acks; v.err = e;
        v.a = a; v.b = b; v.ca = ca; v.cb = cb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Called at #1 after a posedge, so the next posedge is edge 0 of the press.
    // Key is high for edges 0..hold-1; the loop bound covers release debounce.
    task automatic press(input logic [4:0] code, input logic sw_exec, input int hold,
                         output int acks, output int ack_edge, output logic err_seen);
        acks = 0; ack_edge = -1; err_seen = 1'b0;
        key_code  = code;
        SW        = ~sw_exec;
        key_valid = 1'b1;
        for (int e = 0; e < hold + 14; e++) begin
            @(posedge clk); #1;
            if (key_ack) begin
                acks++;
                ack_edge = e;
            end
            if (err) err_seen = 1'b1;
            if (e == hold - 1) key_valid = 1'b0;
            if (e == DC + 2) SW = sw_exec;
            if (e == DC + 3) SW = ~sw_exec;
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] ca, input logic [3:0] cb);
        chk({tag, " operandA"}, operandA, a);
        chk({tag, " operandB"}, operandB, b);
        chk({tag, " cntA"}, 32'(cntA), 32'(ca));
        chk({tag, " cntB"}, 32'(cntB), 32'(cb));
    endtask

    initial begin
        int acks, ack_edge;
        logic err_seen;
        string tag;

        //            code  sw hold acks err  A         B         cA cB
        vecs.push_back(mk(5'd1,  0, 8,   1, 0, 32'h1,    32'h0,    1, 0));
        vecs.push_back(mk(5'd2,  0, 8,   1, 0, 32'h12,   32'h0,    2, 0));
        vecs.push_back(mk(5'd3,  0, 8,   1, 0, 32'h123,  32'h0,    3, 0));
        vecs.push_back(mk(5'd1,  1, 8,   1, 0, 32'h123,  32'h1,    3, 1));
        vecs.push_back(mk(5'd2,  1, 8,   1, 0, 32'h123,  32'h12,   3, 2));
        vecs.push_back(mk(5'd3,  1, 8,   1, 0, 32'h123,  32'h123,  3, 3));
        vecs.push_back(mk(5'd4,  1, 8,   1, 0, 32'h123,  32'h1234, 3, 4));
        vecs.push_back(mk(5'd5,  1, 8,   1, 1, 32'h123,  32'h1234, 3, 4));
        vecs.push_back(mk(5'd7,  0, 2,   0, 0, 32'h123,  32'h1234, 3, 4));
        vecs.push_back(mk(5'd4,  0, 100, 1, 0, 32'h1234, 32'h1234, 4, 4));
        vecs.push_back(mk(5'd16, 0, 8,   1, 0, 32'h123,  32'h1234, 3, 4));
        vecs.push_back(mk(5'd16, 0, 8,   1, 0, 32'h12,   32'h1234, 2, 4));
        vecs.push_back(mk(5'd16, 0, 8,   1, 0, 32'h1,    32'h1234, 1, 4));
        vecs.push_back(mk(5'd16, 0, 8,   1, 0, 32'h0,    32'h1234, 0, 4));
        vecs.push_back(mk(5'd16, 0, 8,   1, 0, 32'h0,    32'h1234, 0, 4));
        vecs.push_back(mk(5'd0,  0, 8,   1, 0, 32'h0,    32'h1234, 0, 4));
        vecs.push_back(mk(5'd1,  0, 8,   1, 0, 32'h1,    32'h1234, 1, 4));
        vecs.push_back(mk(5'd2,  0, 8,   1, 0, 32'h12,   32'h1234, 2, 4));
        vecs.push_back(mk(5'd17, 1, 8,   1, 0, 32'h12,   32'h0,    2, 0));
        vecs.push_back(mk(5'd3,  1, 8,   1, 0, 32'h12,   32'h3,    2, 1));
        vecs.push_back(mk(5'd4,  1, 8,   1, 0, 32'h12,   32'h34,   2, 2));
        vecs.push_back(mk(5'd18, 0, 8,   1, 0, 32'h0,    32'h0,    0, 0));
        vecs.push_back(mk(5'd5,  0, 8,   1, 0, 32'h5,    32'h0,    1, 0));
        vecs.push_back(mk(5'd25, 0, 8,   1, 1, 32'h5,    32'h0,    1, 0));
        vecs.push_back(mk(5'd6,  0, 8,   1, 0, 32'h56,   32'h0,    2, 0));
        vecs.push_back(mk(5'd17, 0, 8,   1, 0, 32'h0,    32'h0,    0, 0));
        vecs.push_back(mk(5'd7,  0, 8,   1, 0, 32'h7,    32'h0,    1, 0));

        // Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 32'h0, 32'h0, 4'd0, 4'd0);
        chk("reset key_ack", 32'(key_ack), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            tag = $sformatf("vec%0d", i);
            press(vecs[i].code, vecs[i].sw, vecs[i].hold, acks, ack_edge, err_seen);
            chk({tag, " ack count"}, 32'(acks), 32'(vecs[i].acks));
            if (vecs[i].acks > 0)
                chk({tag, " ack edge"}, 32'(ack_edge), 32'(DC + 3));
            chk({tag, " err"}, 32'(err_seen), 32'(vecs[i].err));
            chk_state(tag, vecs[i].a, vecs[i].b, vecs[i].ca, vecs[i].cb);
        end

        // Reset in the middle of DEBOUNCE with the key let go at the same time.
        key_code  = 5'd6;
        SW        = 1'b0;
        key_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst       = 1'b1;
        key_valid = 1'b0;
        @(posedge clk); #1;
        rst  = 1'b0;
        acks = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            if (key_ack) acks++;
        end
        chk("rst-debounce ack count", 32'(acks), 32'd0);
        chk_state("rst-debounce", 32'h0, 32'h0, 4'd0, 4'd0);
        chk("rst-debounce err", 32'(err), 32'd0);

        // A full press afterwards is accepted normally.
        press(5'd8, 1'b0, 8, acks, ack_edge, err_seen);
        chk("post-rst ack count", 32'(acks), 32'd1);
        chk("post-rst ack edge", 32'(ack_edge), 32'(DC + 3));
        chk_state("post-rst", 32'h8, 32'h0, 4'd1, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
